// File: rtl/sha256_msg_padder.sv
// SHA-256 padder feeding sha256_core byte-by-byte; core writes lag acceptance by one cycle; o_ready low outside IDLE/LOAD.
// Optional WAIT watchdog enabled by defining SHA_PAD_TIMEOUT_EN (TIMEOUT_CYC cycles, sets o_err).
module sha256_msg_padder #(
  parameter int          LEN_W       = 32,
  parameter logic [7:0]  CMD_ADDR    = 8'd66,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte,
  input  logic       i_valid,
  input  logic       i_last,
  input  logic       i_end,
  output logic       o_ready,
  output logic [7:0] o_w_addr,
  output logic [7:0] o_data8,
  output logic       o_we,
  input  logic       i_irq,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_PAD80 = 3'd2;
  localparam logic [2:0] S_PADZ  = 3'd3;
  localparam logic [2:0] S_LEN   = 3'd4;
  localparam logic [2:0] S_START = 3'd5;
  localparam logic [2:0] S_WAIT  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [2:0]       resume_q, resume_d;
  logic [6:0]       k_q, k_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             final_q, final_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             we_q, we_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             irq_q;

  logic             idle;
  logic             take;
  logic             end_take;
  logic             irq_rise;
  logic [6:0]       k_cur;
  logic [LEN_W-1:0] cnt_cur;
  logic [63:0]      bit_len;
  logic [2:0]       len_sel;
  logic [7:0]       len_byte;

  assign idle     = (state_q == S_IDLE);
  assign o_ready  = idle | (state_q == S_LOAD);
  assign take     = i_valid & o_ready;
  assign end_take = i_end & ~i_valid & o_ready;
  assign irq_rise = i_irq & ~irq_q;
  // A new message restarts the block index and byte count from zero.
  assign k_cur    = idle ? 7'd0 : k_q;
  assign cnt_cur  = idle ? '0 : cnt_q;
  assign bit_len  = 64'(cnt_q) << 3;
  assign len_sel  = ~k_q[2:0];
  assign len_byte = bit_len[{len_sel, 3'b000} +: 8];

`ifdef SHA_PAD_TIMEOUT_EN
  logic [31:0] wcnt_q, wcnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    first_d  = first_q;
    final_d  = final_q;
    err_d    = err_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
`ifdef SHA_PAD_TIMEOUT_EN
    wcnt_d   = wcnt_q;
`endif
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (idle && (take || end_take)) begin
          first_d = 1'b1;
          final_d = 1'b0;
        end
        if (take) begin
          we_d   = 1'b1;
          addr_d = {2'b00, ~k_cur[5:0]};
          data_d = i_byte;
          k_d    = k_cur + 7'd1;
          cnt_d  = cnt_cur + 1'b1;
          err_d  = (idle ? 1'b0 : err_q) | (&cnt_cur);
          if (i_last) begin
            state_d = S_PAD80;
          end else if (k_cur == 7'd63) begin
            state_d  = S_START;
            resume_d = S_LOAD;
          end else begin
            state_d = S_LOAD;
          end
        end else if (end_take) begin
          k_d     = k_cur;
          cnt_d   = cnt_cur;
          state_d = S_PAD80;
        end
      end
      S_PAD80: begin
        if (k_q[6]) begin
          state_d  = S_START;
          resume_d = S_PAD80;
        end else begin
          we_d    = 1'b1;
          addr_d  = {2'b00, ~k_q[5:0]};
          data_d  = 8'h80;
          k_d     = k_q + 7'd1;
          state_d = S_PADZ;
        end
      end
      S_PADZ: begin
        if (k_q == 7'd56) begin
          state_d = S_LEN;
        end else if (k_q[6]) begin
          state_d  = S_START;
          resume_d = S_PADZ;
        end else begin
          we_d   = 1'b1;
          addr_d = {2'b00, ~k_q[5:0]};
          data_d = 8'h00;
          k_d    = k_q + 7'd1;
        end
      end
      S_LEN: begin
        we_d   = 1'b1;
        addr_d = {2'b00, ~k_q[5:0]};
        data_d = len_byte;
        k_d    = k_q + 7'd1;
        if (k_q == 7'd63) begin
          state_d = S_START;
          final_d = 1'b1;
        end
      end
      S_START: begin
        we_d    = 1'b1;
        addr_d  = CMD_ADDR;
        data_d  = first_q ? 8'h01 : 8'h02;
        first_d = 1'b0;
        state_d = S_WAIT;
`ifdef SHA_PAD_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        // Only a fresh rising edge counts; a level left high from before START is ignored.
        if (irq_rise) begin
          if (final_q) begin
            done_d  = 1'b1;
            final_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            k_d     = 7'd0;
            state_d = resume_q;
          end
        end
`ifdef SHA_PAD_TIMEOUT_EN
        else if (wcnt_q == 32'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          final_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + 32'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      resume_q <= S_LOAD;
      k_q      <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      final_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      final_q  <= final_d;
      err_q    <= err_d;
      done_q   <= done_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      irq_q    <= i_irq;
    end
  end

`ifdef SHA_PAD_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) wcnt_q <= '0;
    else       wcnt_q <= wcnt_d;
  end
`endif

  assign o_we     = we_q;
  assign o_w_addr = addr_q;
  assign o_data8  = data_q;
  assign o_busy   = ~idle;
  assign o_done   = done_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: table of message shapes, hand-written corner sequences,
// and random messages, all checked against a padded-byte-stream reference model.
module tb_sha256_msg_padder;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_byte;
  logic       i_valid, i_last, i_end, i_irq;
  logic       o_ready, o_we, o_busy, o_done, o_err;
  logic [7:0] o_w_addr, o_data8;

  sha256_msg_padder #(.LEN_W(32), .CMD_ADDR(8'd66), .TIMEOUT_CYC(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_byte(i_byte), .i_valid(i_valid),
    .i_last(i_last), .i_end(i_end), .o_ready(o_ready), .o_w_addr(o_w_addr),
    .o_data8(o_data8), .o_we(o_we), .i_irq(i_irq), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int len;
    bit use_end;
    bit gaps;
    int exp_blocks;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] wq[$];
  logic [15:0] exp_q[$];
  logic [7:0]  msg[0:255];
  int  done_cnt  = 0;
  int  cmd_cnt   = 0;
  int  rdy_viol  = 0;
  int  busy_viol = 0;
  int  to_cnt    = 0;
  bit  irq_auto  = 1'b1;
  bit  in_wait   = 1'b0;
  int  irq_cd    = 0;
  int  irq_hold  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor and model core: records writes, counts done pulses, answers START with an irq edge.
  initial begin
    forever begin
      @(negedge i_clk);
      if (o_we) wq.push_back({o_w_addr, o_data8});
      if (o_we && o_w_addr == 8'd66) cmd_cnt++;
      if (o_done) done_cnt++;
      if (o_done && o_busy) busy_viol++;
      if (irq_auto) begin
        if (in_wait && o_ready) rdy_viol++;
        if (irq_cd > 0) begin
          irq_cd--;
          if (irq_cd == 0) begin
            i_irq    = 1'b1;
            irq_hold = 2;
            in_wait  = 1'b0;
          end
        end else if (irq_hold > 0) begin
          irq_hold--;
          if (irq_hold == 0) i_irq = 1'b0;
        end
        if (o_we && o_w_addr == 8'd66) begin
          irq_cd  = $urandom_range(1, 4);
          in_wait = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Reference: pad the message as a flat byte list, then map byte k of each block to address 63-k.
  task automatic build_exp(input int len);
    logic [7:0]  pq[$];
    logic [63:0] bl;
    exp_q.delete();
    for (int i = 0; i < len; i++) pq.push_back(msg[i]);
    pq.push_back(8'h80);
    while (pq.size() % 64 != 56) pq.push_back(8'h00);
    bl = 64'(len) * 64'd8;
    for (int i = 7; i >= 0; i--) pq.push_back(bl[8*i +: 8]);
    for (int idx = 0; idx < pq.size(); idx++) begin
      exp_q.push_back({8'(63 - idx % 64), pq[idx]});
      if (idx % 64 == 63) exp_q.push_back({8'd66, (idx < 64) ? 8'h01 : 8'h02});
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic last);
    logic rdy;
    int   t = 0;
    i_valid = 1'b1; i_byte = b; i_last = last;
    do begin
      rdy = o_ready;
      tick();
      t++;
    end while (!rdy && t < 5000);
    if (!rdy) to_cnt++;
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic send_end();
    logic rdy;
    int   t = 0;
    i_end = 1'b1;
    do begin
      rdy = o_ready;
      tick();
      t++;
    end while (!rdy && t < 5000);
    if (!rdy) to_cnt++;
    i_end = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 20000) begin
      tick();
      t++;
    end
    if (done_cnt == d0) to_cnt++;
    repeat (3) tick();
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
  endtask

  task automatic compare_writes(input string nm);
    int mism = 0;
    chk({nm, " wr_count"}, wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= wq.size() || wq[i] !== exp_q[i]) mism++;
    chk({nm, " wr_mismatches"}, mism, 0);
  endtask

  task automatic run_msg(input int len, input bit use_end, input bit gaps, input string nm);
    int d0, c0;
    wq.delete();
    build_exp(len);
    d0 = done_cnt;
    c0 = cmd_cnt;
    for (int i = 0; i < len; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      drive_byte(msg[i], (i == len - 1) && !use_end);
    end
    if (use_end || len == 0) send_end();
    wait_done(d0);
    chk({nm, " done_pulses"}, done_cnt - d0, 1);
    chk({nm, " blocks"}, cmd_cnt - c0, exp_q.size() / 65);
    compare_writes(nm);
    chk({nm, " busy_after"}, o_busy, 1'b0);
    chk({nm, " timeouts"}, to_cnt, 0);
  endtask

  vec_t vecs[9];

  initial begin
    int d0, c0, t;
    vecs[0] = '{len:0,   use_end:1, gaps:0, exp_blocks:1};
    vecs[1] = '{len:1,   use_end:0, gaps:0, exp_blocks:1};
    vecs[2] = '{len:55,  use_end:0, gaps:1, exp_blocks:1};
    vecs[3] = '{len:56,  use_end:0, gaps:0, exp_blocks:2};
    vecs[4] = '{len:63,  use_end:1, gaps:1, exp_blocks:2};
    vecs[5] = '{len:64,  use_end:0, gaps:0, exp_blocks:2};
    vecs[6] = '{len:64,  use_end:1, gaps:0, exp_blocks:2};
    vecs[7] = '{len:119, use_end:0, gaps:1, exp_blocks:2};
    vecs[8] = '{len:120, use_end:0, gaps:1, exp_blocks:3};

    i_rst = 1'b1; i_byte = 8'h00; i_valid = 1'b0; i_last = 1'b0; i_end = 1'b0; i_irq = 1'b0;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    chk("reset o_we",    o_we,     1'b0);
    chk("reset o_busy",  o_busy,   1'b0);
    chk("reset o_done",  o_done,   1'b0);
    chk("reset o_err",   o_err,    1'b0);
    chk("reset o_ready", o_ready,  1'b1);
    chk("reset o_waddr", o_w_addr, 8'h00);

    // "abc"
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 0, 0, "abc");
    chk("abc k0",    wq[0],  16'h3F61);
    chk("abc pad80", wq[3],  16'h3C80);
    chk("abc len",   wq[63], 16'h0018);
    chk("abc cmd",   wq[64], 16'h4201);

    // empty message via i_end in IDLE
    run_msg(0, 1, 0, "empty");
    chk("empty pad80", wq[0],  16'h3F80);
    chk("empty len",   wq[63], 16'h0000);
    chk("empty cmd",   wq[64], 16'h4201);

    fill_random(56);
    run_msg(56, 0, 0, "len56");
    chk("len56 pad80",  wq[56],  16'h0780);
    chk("len56 cmd1",   wq[64],  16'h4201);
    chk("len56 zero63", wq[65],  16'h3F00);
    chk("len56 len1",   wq[127], 16'h0101);
    chk("len56 len0",   wq[128], 16'h00C0);
    chk("len56 cmd2",   wq[129], 16'h4202);

    fill_random(64);
    run_msg(64, 0, 1, "len64");
    chk("len64 cmd1",  wq[64],  16'h4201);
    chk("len64 pad80", wq[65],  16'h3F80);
    chk("len64 len1",  wq[127], 16'h0102);
    chk("len64 len0",  wq[128], 16'h0000);
    chk("len64 cmd2",  wq[129], 16'h4202);

    foreach (vecs[i]) begin
      fill_random(vecs[i].len);
      run_msg(vecs[i].len, vecs[i].use_end, vecs[i].gaps, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table_blocks", i), exp_q.size() / 65, vecs[i].exp_blocks);
    end

    // i_valid together with i_end: i_end must be ignored
    msg[0] = 8'h5A; msg[1] = 8'hA5;
    wq.delete(); build_exp(2); d0 = done_cnt;
    i_end = 1'b1;
    drive_byte(msg[0], 1'b0);
    i_end = 1'b0;
    chk("valid_end busy", o_busy, 1'b1);
    drive_byte(msg[1], 1'b1);
    wait_done(d0);
    compare_writes("valid_end");

    // reset at k=20
    wq.delete();
    for (int i = 0; i < 20; i++) drive_byte(8'(i + 1), 1'b0);
    chk("mid_rst busy_before", o_busy, 1'b1);
    i_rst = 1'b1;
    tick();
    chk("mid_rst o_we",    o_we,    1'b0);
    chk("mid_rst o_busy",  o_busy,  1'b0);
    chk("mid_rst o_ready", o_ready, 1'b1);
    i_rst = 1'b0;
    tick();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run_msg(3, 0, 1, "abc_after_rst");

    // stale irq level held high before START must not advance WAIT
    irq_auto = 1'b0;
    repeat (4) tick();
    i_irq = 1'b1;
    wq.delete(); build_exp(3); d0 = done_cnt; c0 = cmd_cnt;
    for (int i = 0; i < 3; i++) drive_byte(msg[i], i == 2);
    t = 0;
    while (cmd_cnt == c0 && t < 500) begin tick(); t++; end
    chk("stale cmd_seen", cmd_cnt - c0, 1);
    repeat (10) tick();
    chk("stale no_done", done_cnt - d0, 0);
    chk("stale busy",    o_busy,  1'b1);
    chk("stale ready",   o_ready, 1'b0);
    i_irq = 1'b0;
    repeat (2) tick();
    i_irq = 1'b1;
    wait_done(d0);
    i_irq = 1'b0;
    chk("stale done", done_cnt - d0, 1);
    compare_writes("stale");
    irq_auto = 1'b1;

    for (int r = 0; r < 12; r++) begin
      int len;
      len = $urandom_range(0, 140);
      fill_random(len);
      run_msg(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end

    chk("ready_in_wait violations", rdy_viol, 0);
    chk("busy_with_done violations", busy_viol, 0);
    chk("err clean", o_err, 1'b0);

`ifdef SHA_PAD_TIMEOUT_EN
    irq_auto = 1'b0;
    repeat (4) tick();
    i_irq = 1'b0;
    d0 = done_cnt; c0 = cmd_cnt;
    for (int i = 0; i < 3; i++) drive_byte(msg[i], i == 2);
    t = 0;
    while (cmd_cnt == c0 && t < 500) begin tick(); t++; end
    repeat (20) tick();
    chk("timeout err",  o_err,  1'b1);
    chk("timeout busy", o_busy, 1'b0);
    chk("timeout no_done", done_cnt - d0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
